// File: rtl/lab9_sysid_pkg.sv
// Shared types and constants for the system-ID checker and its helpers.
// The sysid slave exposes two words: the ID at address 0 and the build timestamp at address 1.
package lab9_sysid_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD_ID = 2'd1,
      RD_TS = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;

   localparam logic [31:0] DEFAULT_EXPECTED_ID    = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_EXPECTED_TS    = 32'd1509475608;
   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1023;

endpackage

// File: rtl/lab9_sysid_stall_timer.sv
// Saturating 16-bit stall counter for Avalon-MM masters.
// Expired is high once the count equals the limit; clear has priority over counting.
module lab9_sysid_stall_timer (
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        count_en,
   input  logic [15:0] limit,
   output logic        expired
);

   logic [15:0] count_q;
   logic [15:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = 16'd0;
      end else if (count_en && (count_q != limit)) begin
         count_d = count_q + 16'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= 16'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == limit);

endmodule

// File: rtl/lab9_soc_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words and
// compares them against the expected build constants, reporting pass/fail.
module lab9_soc_sysid_checker
   import lab9_sysid_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
   parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter bit          AUTO_START     = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES);

   state_t      state_q, state_d;
   logic        pending_q, pending_d;
   logic        avm_address_q, avm_address_d;
   logic        avm_read_q, avm_read_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic        id_ok_q, id_ok_d;
   logic        ts_ok_q, ts_ok_d;
   logic        timeout_q, timeout_d;
   logic [31:0] id_value_q, id_value_d;
   logic [31:0] ts_value_q, ts_value_d;

   logic timer_clear;
   logic timer_en;
   logic timer_expired;

   lab9_sysid_stall_timer u_stall_timer (
      .clock    (clock),
      .reset    (reset),
      .clear    (timer_clear),
      .count_en (timer_en),
      .limit    (STALL_LIMIT),
      .expired  (timer_expired)
   );

   // An accept on the limit cycle wins over the timeout; only a still-stalled read expires.
   always_comb begin
      state_d       = state_q;
      pending_d     = pending_q;
      avm_address_d = avm_address_q;
      avm_read_d    = avm_read_q;
      busy_d        = busy_q;
      done_d        = done_q;
      pass_d        = pass_q;
      id_ok_d       = id_ok_q;
      ts_ok_d       = ts_ok_q;
      timeout_d     = timeout_q;
      id_value_d    = id_value_q;
      ts_value_d    = ts_value_q;
      timer_clear   = 1'b0;
      timer_en      = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start || pending_q) begin
               state_d       = RD_ID;
               pending_d     = 1'b0;
               avm_address_d = SYSID_ADDR_ID;
               avm_read_d    = 1'b1;
               busy_d        = 1'b1;
               done_d        = 1'b0;
               pass_d        = 1'b0;
               id_ok_d       = 1'b0;
               ts_ok_d       = 1'b0;
               timeout_d     = 1'b0;
               id_value_d    = 32'd0;
               ts_value_d    = 32'd0;
               timer_clear   = 1'b1;
            end
         end
         RD_ID: begin
            if (!avm_waitrequest) begin
               state_d       = RD_TS;
               id_value_d    = avm_readdata;
               id_ok_d       = (avm_readdata == EXPECTED_ID);
               avm_address_d = SYSID_ADDR_TS;
               timer_clear   = 1'b1;
            end else if (timer_expired) begin
               state_d       = DONE;
               avm_address_d = SYSID_ADDR_ID;
               avm_read_d    = 1'b0;
               busy_d        = 1'b0;
               done_d        = 1'b1;
               timeout_d     = 1'b1;
               pass_d        = 1'b0;
            end else begin
               timer_en = 1'b1;
            end
         end
         RD_TS: begin
            if (!avm_waitrequest) begin
               state_d       = DONE;
               ts_value_d    = avm_readdata;
               ts_ok_d       = (avm_readdata == EXPECTED_TS);
               pass_d        = id_ok_q && (avm_readdata == EXPECTED_TS);
               avm_address_d = SYSID_ADDR_ID;
               avm_read_d    = 1'b0;
               busy_d        = 1'b0;
               done_d        = 1'b1;
            end else if (timer_expired) begin
               state_d       = DONE;
               avm_address_d = SYSID_ADDR_ID;
               avm_read_d    = 1'b0;
               busy_d        = 1'b0;
               done_d        = 1'b1;
               timeout_d     = 1'b1;
               pass_d        = 1'b0;
            end else begin
               timer_en = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         pending_q     <= AUTO_START;
         avm_address_q <= SYSID_ADDR_ID;
         avm_read_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         id_ok_q       <= 1'b0;
         ts_ok_q       <= 1'b0;
         timeout_q     <= 1'b0;
         id_value_q    <= 32'd0;
         ts_value_q    <= 32'd0;
      end else begin
         state_q       <= state_d;
         pending_q     <= pending_d;
         avm_address_q <= avm_address_d;
         avm_read_q    <= avm_read_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         pass_q        <= pass_d;
         id_ok_q       <= id_ok_d;
         ts_ok_q       <= ts_ok_d;
         timeout_q     <= timeout_d;
         id_value_q    <= id_value_d;
         ts_value_q    <= ts_value_d;
      end
   end

   assign avm_address = avm_address_q;
   assign avm_read    = avm_read_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign id_ok       = id_ok_q;
   assign ts_ok       = ts_ok_q;
   assign timeout     = timeout_q;
   assign id_value    = id_value_q;
   assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_lab9_soc_sysid_checker.sv
// Directed bench for lab9_soc_sysid_checker: a default instance with auto-start
// and a second instance with an 8-cycle timeout, each driven by a small sysid slave model.
module tb_lab9_soc_sysid_checker;

   localparam logic [31:0] GOOD_TS = 32'd1509475608;
   localparam logic [31:0] BAD_TS  = 32'd1509475609;

   logic clock;
   logic reset;

   // Instance 1: default parameters, auto-start
   logic        start;
   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        busy, done, pass, id_ok, ts_ok, timeout;
   logic [31:0] id_value, ts_value;
   logic [31:0] id_word = 32'd0;
   logic [31:0] ts_word = 32'd1509475608;
   int          stall_len = 0;
   int          stall_cnt = 0;

   // Instance 2: short timeout, no auto-start
   logic        start2;
   logic        avm_address2;
   logic        avm_read2;
   logic        avm_waitrequest2;
   logic [31:0] avm_readdata2;
   logic        busy2, done2, pass2, id_ok2, ts_ok2, timeout2;
   logic [31:0] id_value2, ts_value2;
   logic        stuck_ts2 = 1'b0;
   int          stall_len2 = 0;
   int          stall_cnt2 = 0;

   int tests_run    = 0;
   int tests_failed = 0;

   lab9_soc_sysid_checker dut (
      .clock           (clock),
      .reset           (reset),
      .start           (start),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_waitrequest (avm_waitrequest),
      .avm_readdata    (avm_readdata),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .id_ok           (id_ok),
      .ts_ok           (ts_ok),
      .timeout         (timeout),
      .id_value        (id_value),
      .ts_value        (ts_value)
   );

   lab9_soc_sysid_checker #(
      .TIMEOUT_CYCLES (8),
      .AUTO_START     (1'b0)
   ) dut_to (
      .clock           (clock),
      .reset           (reset),
      .start           (start2),
      .avm_address     (avm_address2),
      .avm_read        (avm_read2),
      .avm_waitrequest (avm_waitrequest2),
      .avm_readdata    (avm_readdata2),
      .busy            (busy2),
      .done            (done2),
      .pass            (pass2),
      .id_ok           (id_ok2),
      .ts_ok           (ts_ok2),
      .timeout         (timeout2),
      .id_value        (id_value2),
      .ts_value        (ts_value2)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Sysid slave models: stall for stall_len cycles on every read, then accept
   assign avm_readdata     = avm_address ? ts_word : id_word;
   assign avm_waitrequest  = avm_read && (stall_cnt < stall_len);
   assign avm_readdata2    = avm_address2 ? GOOD_TS : 32'd0;
   assign avm_waitrequest2 = avm_read2 && (stuck_ts2 ? avm_address2 : (stall_cnt2 < stall_len2));

   always @(posedge clock) begin
      stall_cnt  <= (avm_read && avm_waitrequest) ? stall_cnt + 1 : 0;
      stall_cnt2 <= (avm_read2 && avm_waitrequest2) ? stall_cnt2 + 1 : 0;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Pulse start for one edge; returns at the negedge right after the sampling edge
   task automatic applyStimulus(input bit second);
      if (second) start2 = 1'b1; else start = 1'b1;
      @(negedge clock);
      start  = 1'b0;
      start2 = 1'b0;
   endtask

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      start2 = 1'b0;

      // Reset state
      @(negedge clock);
      checkOutput("rst_read", {31'd0, avm_read}, 32'd0);
      checkOutput("rst_addr", {31'd0, avm_address}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_ts_value", ts_value, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      // Auto-start check against a matching slave
      @(negedge clock);
      checkOutput("auto_read", {31'd0, avm_read}, 32'd1);
      checkOutput("auto_addr0", {31'd0, avm_address}, 32'd0);
      @(negedge clock);
      checkOutput("auto_addr1", {31'd0, avm_address}, 32'd1);
      checkOutput("auto_done_early", {31'd0, done}, 32'd0);
      @(negedge clock);
      checkOutput("auto_done", {31'd0, done}, 32'd1);
      checkOutput("auto_pass", {31'd0, pass}, 32'd1);
      checkOutput("auto_busy", {31'd0, busy}, 32'd0);
      checkOutput("auto_read_off", {31'd0, avm_read}, 32'd0);
      checkOutput("auto_id_value", id_value, 32'd0);
      checkOutput("auto_ts_value", ts_value, GOOD_TS);
      checkOutput("idle2_done", {31'd0, done2}, 32'd0);
      checkOutput("idle2_read", {31'd0, avm_read2}, 32'd0);

      // Timestamp mismatch
      ts_word = BAD_TS;
      applyStimulus(1'b0);
      checkOutput("bad_clr_ts_value", ts_value, 32'd0);
      checkOutput("bad_clr_done", {31'd0, done}, 32'd0);
      checkOutput("bad_busy", {31'd0, busy}, 32'd1);
      repeat (2) @(negedge clock);
      checkOutput("bad_done", {31'd0, done}, 32'd1);
      checkOutput("bad_id_ok", {31'd0, id_ok}, 32'd1);
      checkOutput("bad_ts_ok", {31'd0, ts_ok}, 32'd0);
      checkOutput("bad_pass", {31'd0, pass}, 32'd0);
      checkOutput("bad_ts_value", ts_value, BAD_TS);

      // Five wait cycles on each read: done 13 cycles after start
      ts_word   = GOOD_TS;
      stall_len = 5;
      applyStimulus(1'b0);
      for (int k = 1; k <= 13; k++) begin
         if (k <= 12) begin
            checkOutput($sformatf("stall_read_c%0d", k), {31'd0, avm_read}, 32'd1);
            checkOutput($sformatf("stall_addr_c%0d", k), {31'd0, avm_address}, (k <= 6) ? 32'd0 : 32'd1);
            checkOutput($sformatf("stall_done_c%0d", k), {31'd0, done}, 32'd0);
         end else begin
            checkOutput("stall_done", {31'd0, done}, 32'd1);
            checkOutput("stall_pass", {31'd0, pass}, 32'd1);
         end
         if (k < 13) @(negedge clock);
      end

      // Start pulse while busy is ignored
      stall_len = 0;
      applyStimulus(1'b0);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      checkOutput("extra_done", {31'd0, done}, 32'd1);
      repeat (3) @(negedge clock);
      checkOutput("extra_still_done", {31'd0, done}, 32'd1);
      checkOutput("extra_no_read", {31'd0, avm_read}, 32'd0);
      checkOutput("extra_busy", {31'd0, busy}, 32'd0);

      // Reset during the timestamp read, then auto-start again
      stall_len = 3;
      applyStimulus(1'b0);
      repeat (4) @(negedge clock);
      checkOutput("midrst_addr1", {31'd0, avm_address}, 32'd1);
      checkOutput("midrst_read", {31'd0, avm_read}, 32'd1);
      #2 reset = 1'b1;
      #1;
      checkOutput("midrst_read_off", {31'd0, avm_read}, 32'd0);
      checkOutput("midrst_addr_off", {31'd0, avm_address}, 32'd0);
      checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
      checkOutput("midrst_id_ok", {31'd0, id_ok}, 32'd0);
      @(negedge clock);
      reset     = 1'b0;
      stall_len = 0;
      @(negedge clock);
      checkOutput("reauto_read", {31'd0, avm_read}, 32'd1);
      checkOutput("reauto_addr0", {31'd0, avm_address}, 32'd0);
      repeat (2) @(negedge clock);
      checkOutput("reauto_done", {31'd0, done}, 32'd1);
      checkOutput("reauto_pass", {31'd0, pass}, 32'd1);

      // Timeout instance: accept on exactly the limit cycle is not a timeout
      stall_len2 = 8;
      applyStimulus(1'b1);
      repeat (17) @(negedge clock);
      checkOutput("limit_done_early", {31'd0, done2}, 32'd0);
      checkOutput("limit_addr1", {31'd0, avm_address2}, 32'd1);
      @(negedge clock);
      checkOutput("limit_done", {31'd0, done2}, 32'd1);
      checkOutput("limit_timeout", {31'd0, timeout2}, 32'd0);
      checkOutput("limit_pass", {31'd0, pass2}, 32'd1);

      // Timeout instance: timestamp read stuck, expires at R+9
      stall_len2 = 0;
      stuck_ts2  = 1'b1;
      applyStimulus(1'b1);
      repeat (9) @(negedge clock);
      checkOutput("to_read_held", {31'd0, avm_read2}, 32'd1);
      checkOutput("to_timeout_early", {31'd0, timeout2}, 32'd0);
      @(negedge clock);
      checkOutput("to_read_drop", {31'd0, avm_read2}, 32'd0);
      checkOutput("to_timeout", {31'd0, timeout2}, 32'd1);
      checkOutput("to_done", {31'd0, done2}, 32'd1);
      checkOutput("to_id_ok", {31'd0, id_ok2}, 32'd1);
      checkOutput("to_ts_ok", {31'd0, ts_ok2}, 32'd0);
      checkOutput("to_pass", {31'd0, pass2}, 32'd0);
      checkOutput("to_ts_value", ts_value2, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
